uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serializer core between two byte-stream requesters, for example the CPU-side UART controller and a hardware trace/log source. It accepts a byte from the winning requester through a valid/ready handshake and issues it to the core as a one-cycle `tx_valid` pulse. It then tracks the core's `busy_o` through start and completion before granting again. It sits between the requesters and `uart_tx`; baud rate, parity and stop-bit configuration stay with the core's owner.

## Interface
- `START_TIMEOUT`, default 8: cycles allowed after the `tx_valid` pulse for `busy_i` to rise before the byte is abandoned.
- `CNT_W`, default 16: width of the per-requester sent-byte counters.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 2: requester k has a byte on `req_data{k}_i`.
- `req_data0_i` in 8: byte from requester 0.
- `req_data1_i` in 8: byte from requester 1.
- `req_lock_i` in 2: requester k holds its grant across bytes while high.
- `req_ready_o` out 2: byte from requester k is accepted this cycle.
- `tx_data_o` out 8: to `uart_tx.tx_data_i`.
- `tx_valid_o` out 1: to `uart_tx.tx_valid_i`, one-cycle pulse.
- `busy_i` in 1: from `uart_tx.busy_o`.
- `active_o` out 1: a byte is in flight (state ≠ IDLE).
- `owner_o` out 1: index of the current or last granted requester.
- `done_o` out 1: one-cycle pulse when a byte finishes (busy falls).
- `timeout_o` out 1: one-cycle pulse when a byte is abandoned at start.
- `sent_cnt0_o`, `sent_cnt1_o` out CNT_W: completed bytes per requester, wrap at 2^CNT_W.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, arbitration (combinational):
  - Lock held: if the previous owner's `req_lock_i` is high, only the owner is eligible, and the other requester waits even when valid.
  - Otherwise, if exactly one requester is valid, it wins. If both are valid, `prio` wins.
  - Accept: `req_ready_o[w]` = 1 in that cycle. `req_data{w}_i` is registered into `tx_data_o`, `owner_o` <= w, and the FSM goes to START.
  - No valid requester: stay in IDLE with `req_ready_o` = 0.
- START: `tx_valid_o` = 1 for this cycle only. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - `busy_i` = 1: go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT`, pulse `timeout_o`, drop the byte without counting it, and go to IDLE. `prio` is updated as on completion.
- WAIT_DONE: on `busy_i` = 0, pulse `done_o`, increment `sent_cnt{owner}_o` (wrap-around), update `prio`, and go to IDLE.
- `prio` update:
  - If `req_lock_i[owner]` = 1, `prio` <= owner.
  - Otherwise `prio` <= ~owner, which gives fairness.
- `req_ready_o` is 0 in every state except IDLE, and 0 while `rst_i` = 1.
- `tx_data_o` is held stable from START until the next accept.
- Lock is sampled only in IDLE and at byte completion. Dropping lock mid-byte releases the grant after that byte.

## Timing
- Reset (`rst_i` high at a clock edge) sets:
  - state = IDLE, `prio` = 0, `owner_o` = 0
  - `tx_data_o` = 0, `tx_valid_o` = 0, `active_o` = 0
  - `done_o` = 0, `timeout_o` = 0
  - both counters = 0
- Reset mid-byte aborts the byte without pulsing `done_o` or `timeout_o`. The `uart_tx` core is reset from the same `rst_i` at integration.
- Handshake timing for a byte accepted in cycle N:
  - N+1: `tx_valid_o` = 1.
  - N+2 onward: WAIT_BUSY.
  - Core busy seen at cycle M: WAIT_DONE from M+1.
  - Busy low seen at cycle D: `done_o` = 1 in cycle D+1 and the FSM is back in IDLE.
  - Next accept is possible no earlier than D+1.
- Minimum spacing between accepts: 4 cycles plus the frame length.
- `done_o` and `timeout_o` are never high in the same cycle.
- Simultaneous valid on both requesters with no lock: strict alternation 0, 1, 0, 1, starting from requester 0 after reset.

## Test plan
- **Single byte:** after reset, req0 sends 0xA5 and the core model raises busy 1 cycle after `tx_valid` and holds it 100 cycles. Expect `req_ready_o` = 01 in the accept cycle, `tx_valid_o` pulse one cycle later with `tx_data_o` = 0xA5, `done_o` after busy falls, `sent_cnt0_o` = 1.
- **Round-robin:** both requesters continuously valid (req0 0x11, req1 0x22) for 4 bytes. Expect grant order 0, 1, 0, 1, data 11, 22, 11, 22, each counter = 2.
- **Lock:** req1 locked for 3 bytes while req0 is valid throughout. Expect 3 consecutive req1 grants, then req0 granted on the next IDLE after lock drops.
- **Start timeout:** `busy_i` held 0 after `tx_valid`. Expect `timeout_o` pulse exactly `START_TIMEOUT` cycles into WAIT_BUSY, counters unchanged, return to IDLE, next grant goes to the other requester.
- **Reset mid-frame:** assert `rst_i` in WAIT_DONE. Expect all outputs at reset values on the next cycle, no `done_o`, and normal operation afterwards.
- **Counter wrap:** with `CNT_W` = 2, send 5 bytes from req0. Expect `sent_cnt0_o` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter and sequencer that shares one uart_tx
//               serializer between two byte-stream requesters, with lock,
//               start timeout and per-requester sent-byte counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int START_TIMEOUT = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    input  logic [7:0]       req_data0_i,
    input  logic [7:0]       req_data1_i,
    input  logic [1:0]       req_lock_i,
    output logic [1:0]       req_ready_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             busy_i,
    output logic             active_o,
    output logic             owner_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] sent_cnt0_o,
    output logic [CNT_W-1:0] sent_cnt1_o
);

    localparam int c_TO_LIM = (START_TIMEOUT < 1) ? 1 : START_TIMEOUT;
    localparam int c_TO_W   = (c_TO_LIM < 2) ? 1 : $clog2(c_TO_LIM + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(c_TO_LIM - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_owner;
    logic [7:0]        r_tx_data;
    logic              r_done;
    logic              r_timeout;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic [1:0]        w_eligible;
    logic              w_grant_vld;
    logic              w_grant_idx;
    logic              w_accept;
    logic              w_finish;
    logic              w_abandon;
    logic              w_tx_valid;
    logic              w_to_clr;
    logic              w_to_inc;

    // A held lock narrows eligibility to the previous owner only.
    always_comb begin
        w_eligible  = req_valid_i;
        if (req_lock_i[r_owner]) begin
            w_eligible = req_valid_i & (r_owner ? 2'b10 : 2'b01);
        end
        w_grant_vld = |w_eligible;
        w_grant_idx = (w_eligible == 2'b11) ? r_prio : w_eligible[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_abandon   = 1'b0;
        w_tx_valid  = 1'b0;
        w_to_clr    = 1'b0;
        w_to_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_valid  = 1'b1;
                w_to_clr    = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Busy seen on the final allowed cycle still counts as a start.
                if (busy_i) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_abandon   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_i) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_tx_data <= 8'h00;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_to_cnt  <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            r_done    <= w_finish;
            r_timeout <= w_abandon;
            if (w_accept) begin
                r_tx_data <= w_grant_idx ? req_data1_i : req_data0_i;
                r_owner   <= w_grant_idx;
            end
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            // Lock is re-sampled at the end of every byte, abandoned or not.
            if (w_finish || w_abandon) begin
                r_prio <= req_lock_i[r_owner] ? r_owner : ~r_owner;
            end
            if (w_finish) begin
                if (r_owner) begin
                    r_cnt1 <= r_cnt1 + 1'b1;
                end else begin
                    r_cnt0 <= r_cnt0 + 1'b1;
                end
            end
        end
    end

    assign req_ready_o = (w_accept && !rst_i) ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = w_tx_valid;
    assign active_o    = (r_state != S_IDLE);
    assign owner_o     = r_owner;
    assign done_o      = r_done;
    assign timeout_o   = r_timeout;
    assign sent_cnt0_o = r_cnt0;
    assign sent_cnt1_o = r_cnt1;

endmodule

`default_nettype wire
